// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    F_ACC = 2'd1,
    D_ACC = 2'd2
  } arb_state_t;

  function automatic logic is_acc(input arb_state_t s);
    return (s == F_ACC) || (s == D_ACC);
  endfunction

endpackage

// File: rtl/arb_timeout_cnt.sv
// Access timeout counter: cleared while the arbiter is idle, advanced on
// every access cycle that has no acknowledge. 'expired' fires in the cycle
// whose increment would bring the count up to TIMEOUT_CYC.
module arb_timeout_cnt
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count;

  // Count unacknowledged access cycles; clear has priority over tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = tick && (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one shared memory port.
// Optional macro ARB_RR_EN: round-robin between the two requesters when both
// ask in the same idle cycle; otherwise the data port has fixed priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_done,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err,
  output logic              busy
);

  arb_state_t state;
  logic       grant_f;
  logic       grant_d;
  logic       tmo_clear;
  logic       tmo_tick;
  logic       tmo_expired;

`ifdef ARB_RR_EN
  logic last_fetch;

  // Pick the requester that was not served last when both are asking.
  always_comb begin
    grant_f = 1'b0;
    grant_d = 1'b0;
    if (f_req && d_req) begin
      grant_d = last_fetch;
      grant_f = !last_fetch;
    end else begin
      grant_f = f_req;
      grant_d = d_req;
    end
  end

  // Remember who won the most recent grant; reset as if fetch went last.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_fetch <= 1'b1;
    end else if (state == IDLE) begin
      if (grant_f) begin
        last_fetch <= 1'b1;
      end else if (grant_d) begin
        last_fetch <= 1'b0;
      end
    end
  end
`else
  // Data requests always win; a fetch only goes through when data is quiet.
  always_comb begin
    grant_d = d_req;
    grant_f = f_req && !d_req;
  end
`endif

  assign tmo_clear = (state == IDLE);
  assign tmo_tick  = is_acc(state) && !mem_ack;
  assign busy      = (state != IDLE);

  arb_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmo_clear),
    .tick    (tmo_tick),
    .expired (tmo_expired)
  );

  // Main FSM: latch the winner's request, hold the memory port until ack or
  // timeout, then return to idle with a one-cycle done (and err on timeout).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      f_gnt     <= 1'b0;
      f_done    <= 1'b0;
      f_rdata   <= '0;
      d_gnt     <= 1'b0;
      d_done    <= 1'b0;
      d_rdata   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err       <= 1'b0;
    end else begin
      f_gnt  <= 1'b0;
      d_gnt  <= 1'b0;
      f_done <= 1'b0;
      d_done <= 1'b0;
      err    <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state     <= D_ACC;
            d_gnt     <= 1'b1;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
          end else if (grant_f) begin
            state     <= F_ACC;
            f_gnt     <= 1'b1;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= f_addr;
            mem_wdata <= '0;
          end
        end
        F_ACC, D_ACC: begin
          if (mem_ack || tmo_expired) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            err     <= !mem_ack;
            if (state == F_ACC) begin
              f_done <= 1'b1;
              if (mem_ack) begin
                f_rdata <= mem_rdata;
              end
            end else begin
              d_done <= 1'b1;
              if (mem_ack && !mem_we) begin
                d_rdata <= mem_rdata;
              end
            end
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a table of single accesses,
// a mid-access reset sequence and a simultaneous-request arbitration run.
// Build with or without ARB_RR_EN; arbitration expectations follow the macro.
module tb_mem_port_arbiter;

  localparam int TIMEOUT_CYC = 8;
  localparam int MAX_WAIT    = 40;
  localparam int NUM_VECS    = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req;
  logic [15:0] f_addr;
  logic        f_gnt;
  logic        f_done;
  logic [15:0] f_rdata;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_gnt;
  logic        d_done;
  logic [15:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        err;
  logic        busy;

  typedef struct {
    logic        is_data;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          ack_at;
    logic [15:0] rdata;
    int          exp_done;
    logic        exp_err;
    logic [15:0] exp_rdata;
  } vec_t;

  typedef struct {
    int          done_cycle;
    logic        err;
    logic [15:0] rdata;
    int          acc_cycles;
  } exp_t;

  vec_t vecs [NUM_VECS];
  exp_t exp_q[$];
  logic exp_gnt_d[$];

  int tests_run    = 0;
  int tests_failed = 0;

  mem_port_arbiter #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_gnt     (f_gnt),
    .f_done    (f_done),
    .f_rdata   (f_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_done    (d_done),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .err       (err),
    .busy      (busy)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Hard stop in case something never terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_f_gnt"},     32'(f_gnt),     0);
    check({tag, "_f_done"},    32'(f_done),    0);
    check({tag, "_f_rdata"},   32'(f_rdata),   0);
    check({tag, "_d_gnt"},     32'(d_gnt),     0);
    check({tag, "_d_done"},    32'(d_done),    0);
    check({tag, "_d_rdata"},   32'(d_rdata),   0);
    check({tag, "_mem_req"},   32'(mem_req),   0);
    check({tag, "_mem_we"},    32'(mem_we),    0);
    check({tag, "_mem_addr"},  32'(mem_addr),  0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
    check({tag, "_err"},       32'(err),       0);
    check({tag, "_busy"},      32'(busy),      0);
  endtask

  // Drive one request at the current (idle) negedge and queue its expectation.
  task automatic apply_stimulus(input vec_t v);
    exp_t e;
    e.done_cycle = v.exp_done;
    e.err        = v.exp_err;
    e.rdata      = v.exp_rdata;
    e.acc_cycles = v.exp_done - 1;
    exp_q.push_back(e);
    if (v.is_data) begin
      d_req   = 1'b1;
      d_we    = v.we;
      d_addr  = v.addr;
      d_wdata = v.wdata;
    end else begin
      f_req  = 1'b1;
      f_addr = v.addr;
    end
  endtask

  // Act as memory for one access and compare against the queued expectation.
  task automatic check_output(input vec_t v);
    exp_t        e;
    int          acc       = 0;
    int          gnt_cnt   = 0;
    int          gnt_cycle = 0;
    bit          done_seen = 0;
    logic        gnt_now;
    logic        done_now;
    logic        other_done;
    logic [15:0] rd_now;
    for (int c = 1; c <= MAX_WAIT; c++) begin
      @(negedge clk);
      gnt_now    = v.is_data ? d_gnt  : f_gnt;
      done_now   = v.is_data ? d_done : f_done;
      other_done = v.is_data ? f_done : d_done;
      rd_now     = v.is_data ? d_rdata : f_rdata;
      if (gnt_now) begin
        gnt_cnt++;
        if (gnt_cycle == 0) gnt_cycle = c;
        if (v.is_data) d_req = 1'b0;
        else           f_req = 1'b0;
      end
      if (done_now) begin
        done_seen = 1;
        mem_ack   = 1'b0;
        e = exp_q.pop_front();
        check("done_cycle", 32'(c), 32'(e.done_cycle));
        check("err", 32'(err), 32'(e.err));
        check("rdata", 32'(rd_now), 32'(e.rdata));
        check("acc_cycles", 32'(acc), 32'(e.acc_cycles));
        check("mem_req_after_done", 32'(mem_req), 0);
        check("other_done", 32'(other_done), 0);
        break;
      end
      if (mem_req) begin
        acc++;
        check("mem_addr", 32'(mem_addr), 32'(v.addr));
        check("mem_we", 32'(mem_we), 32'(v.is_data & v.we));
        if (v.is_data && v.we) check("mem_wdata", 32'(mem_wdata), 32'(v.wdata));
        mem_rdata = v.rdata;
        mem_ack   = (acc == v.ack_at);
      end
    end
    if (!done_seen) begin
      check("done_wait_expired", 0, 1);
      mem_ack = 1'b0;
      f_req   = 1'b0;
      d_req   = 1'b0;
      if (exp_q.size() > 0) e = exp_q.pop_front();
    end
    check("gnt_cycle", 32'(gnt_cycle), 1);
    check("gnt_pulses", 32'(gnt_cnt), 1);
    @(negedge clk);
    check("done_single_pulse", 32'(f_done | d_done), 0);
    check("busy_after_done", 32'(busy), 0);
  endtask

  // Reset during the second access cycle, then a normal fetch afterwards.
  task automatic reset_mid_access();
    vec_t v;
    f_req  = 1'b1;
    f_addr = 16'h0040;
    @(negedge clk);
    check("rst_seq_acc1_mem_req", 32'(mem_req), 1);
    f_req   = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    check("rst_seq_acc2_busy", 32'(busy), 1);
    rst = 1'b0;
    #1;
    check_all_zero("mid_rst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_no_done", 32'(f_done | d_done | err), 0);
    check("post_rst_idle", 32'(busy), 0);
    v = '{is_data:1'b0, we:1'b0, addr:16'h0044, wdata:16'h0, ack_at:1,
          rdata:16'h6C6C, exp_done:2, exp_err:1'b0, exp_rdata:16'h6C6C};
    apply_stimulus(v);
    check_output(v);
  endtask

  // Both requesters ask together four times; each new round is raised in
  // the idle cycle where the previous done pulses.
  task automatic run_arbitration();
    bit   got;
    logic won_d;
    logic exp_d;
    for (int r = 0; r < 4; r++) begin
`ifdef ARB_RR_EN
      exp_gnt_d.push_back((r % 2) == 0);
`else
      exp_gnt_d.push_back(1'b1);
`endif
    end
    for (int r = 0; r < 4; r++) begin
      f_req  = 1'b1;
      f_addr = 16'h0100 + 16'(r);
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 16'h0800 + 16'(r);
      got    = 0;
      won_d  = 1'b0;
      for (int c = 1; c <= MAX_WAIT; c++) begin
        @(negedge clk);
        if (f_gnt || d_gnt) begin
          got   = 1;
          won_d = d_gnt;
          check("arb_gnt_latency", 32'(c), 1);
          check("arb_gnt_exclusive", 32'(f_gnt & d_gnt), 0);
          break;
        end
      end
      exp_d = exp_gnt_d.pop_front();
      if (!got) begin
        check("arb_gnt_wait_expired", 0, 1);
        f_req = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
        continue;
      end
      check("arb_winner_is_data", 32'(won_d), 32'(exp_d));
      f_req     = 1'b0;
      d_req     = 1'b0;
      mem_rdata = 16'h0A00 + 16'(r);
      mem_ack   = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      check("arb_done", 32'(won_d ? d_done : f_done), 1);
      check("arb_err", 32'(err), 0);
    end
    @(negedge clk);
    check("arb_end_idle", 32'(busy), 0);
  endtask

  initial begin
    rst       = 1'b0;
    f_req     = 1'b0;
    f_addr    = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;

    vecs[0] = '{is_data:1'b0, we:1'b0, addr:16'h0010, wdata:16'h0000, ack_at:1,
                rdata:16'h4A5B, exp_done:2, exp_err:1'b0, exp_rdata:16'h4A5B};
    vecs[1] = '{is_data:1'b1, we:1'b0, addr:16'h0300, wdata:16'h0000, ack_at:2,
                rdata:16'hBEEF, exp_done:3, exp_err:1'b0, exp_rdata:16'hBEEF};
    vecs[2] = '{is_data:1'b1, we:1'b1, addr:16'h0200, wdata:16'h1234, ack_at:3,
                rdata:16'hDEAD, exp_done:4, exp_err:1'b0, exp_rdata:16'hBEEF};
    vecs[3] = '{is_data:1'b0, we:1'b0, addr:16'h0020, wdata:16'h0000, ack_at:0,
                rdata:16'h5555, exp_done:9, exp_err:1'b1, exp_rdata:16'h4A5B};
    vecs[4] = '{is_data:1'b1, we:1'b0, addr:16'h0400, wdata:16'h0000, ack_at:8,
                rdata:16'h7788, exp_done:9, exp_err:1'b0, exp_rdata:16'h7788};
    vecs[5] = '{is_data:1'b0, we:1'b0, addr:16'hFFFF, wdata:16'h0000, ack_at:5,
                rdata:16'h0001, exp_done:6, exp_err:1'b0, exp_rdata:16'h0001};
    vecs[6] = '{is_data:1'b1, we:1'b1, addr:16'h0500, wdata:16'hA5A5, ack_at:0,
                rdata:16'h9999, exp_done:9, exp_err:1'b1, exp_rdata:16'h7788};

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NUM_VECS; i++) begin
      apply_stimulus(vecs[i]);
      check_output(vecs[i]);
    end

    reset_mid_access();
    run_arbitration();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 8: number of cycles without mem_ack before an access is aborted (range 2..255).
REQ-002 SHALL have port clk, input, 1: system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port f_req, input, 1: fetch read request; level, held until f_gnt.
REQ-005 SHALL have port f_addr, input, 16: fetch address.
REQ-006 SHALL have port f_gnt, output, 1: one-cycle pulse; fetch request accepted.
REQ-007 SHALL have port f_done, output, 1: one-cycle pulse; fetch access complete.
REQ-008 SHALL have port f_rdata, output, 16: fetched word; valid when f_done is high.
REQ-009 SHALL have ports d_req, input, 1; d_we, input, 1; d_addr, input, 16; d_wdata, input, 16: data request, write enable, address and write word.
REQ-010 SHALL have ports d_gnt, output, 1; d_done, output, 1; d_rdata, output, 16: same meaning as the fetch equivalents.
REQ-011 SHALL have ports mem_req, output, 1; mem_we, output, 1; mem_addr, output, 16; mem_wdata, output, 16: the single shared memory port.
REQ-012 SHALL have ports mem_rdata, input, 16; mem_ack, input, 1: memory read data and completion, both sampled in ACC.
REQ-013 SHALL have port err, output, 1: high with a done pulse when that access timed out.
REQ-014 SHALL have port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-015 SHALL implement the FSM states IDLE, F_ACC and D_ACC.
REQ-016 SHALL sample f_req and d_req only in IDLE; a request seen in any other state is ignored until the next IDLE.
REQ-017 SHALL, in IDLE with a winner, latch addr, wdata and we (we=0 for fetch) into registers, then move to F_ACC or D_ACC.
REQ-018 SHALL hold mem_req=1 and stable mem_addr, mem_we and mem_wdata for every cycle spent in F_ACC or D_ACC.
REQ-019 SHALL pulse the winner's gnt in the first cycle of the ACC state only.
REQ-020 SHALL, on mem_ack=1 in ACC, go to IDLE next cycle with mem_req=0 and the matching done=1 for that single cycle.
REQ-021 SHALL load rdata from mem_rdata on read completion and leave rdata unchanged on writes.
REQ-022 SHALL allow a new arbitration in the same IDLE cycle in which done pulses.
REQ-023 SHALL clear the timeout counter on ACC entry and increment it each ACC cycle without mem_ack.
REQ-024 SHALL, when the count reaches TIMEOUT_CYC, go to IDLE, pulse done with err=1 and leave rdata unchanged.
REQ-025 SHALL give mem_ack priority over the timeout when both occur in the same cycle (err=0).
REQ-026 SHALL require each requester to drop its req the cycle after its gnt; a req still high in the next IDLE is treated as a new request.
REQ-027 SHALL keep the minimum access at 2 cycles from req sample to done (ack in the first ACC cycle).

Reset
REQ-028 SHALL, while rst=0 and regardless of the cycle, force state IDLE and drive every output to 0, rdata registers included.
REQ-029 SHALL set the counter to 0 and the round-robin pointer to "fetch last" during reset.
REQ-030 SHALL, on reset in mid-access, abandon the access with no done and no err pulse.

Configuration
REQ-031 SHALL, with ARB_RR_EN defined, grant the requester not granted last when both request in IDLE, and update the pointer on each grant.
REQ-032 SHALL, without ARB_RR_EN, give d_req fixed priority over f_req; the pointer logic is absent, and fetch starvation is accepted.

Structure
REQ-033 SHALL place the FSM state enum, ADDR_W=16 and DATA_W=16 in shared package mem_arb_pkg.
REQ-034 SHALL implement the timeout counter as sub-module arb_timeout_cnt (inputs clear and tick; output expired).

Verification
REQ-035 SHALL check a single fetch: f_req, f_addr=0x0010, ack on 1st ACC cycle with rdata=0x4A5B -> f_gnt in cycle 1, f_done with f_rdata=0x4A5B in cycle 2, err=0.
REQ-036 SHALL check a data write: d_we=1, d_addr=0x0200, d_wdata=0x1234, ack after 3 cycles -> mem_we=1, mem_wdata=0x1234 held 3 cycles, d_done once, d_rdata unchanged.
REQ-037 SHALL check simultaneous f_req and d_req, both re-raised 4 times -> without ARB_RR_EN all 4 grants go to data; with it, grants alternate D,F,D,F.
REQ-038 SHALL check no ack, TIMEOUT_CYC=8 -> done and err together 8 cycles after ACC entry, then mem_req=0.
REQ-039 SHALL check ack and timeout in the same cycle -> done with err=0, rdata loaded.
REQ-040 SHALL check rst=0 in the 2nd ACC cycle -> all outputs 0 immediately, no done; after release, a new f_req is granted normally.
